// File: rtl/param_digital_lock.sv
// Parameterised keypad combination lock: set a code, confirm it, lock, then unlock.
// Repeated wrong unlock attempts freeze the keypad; a stalled partial entry can time out.
module param_digital_lock #(
  parameter int NUM_KEYS      = 4,
  parameter int CODE_LEN      = 4,
  parameter int MAX_FAILS     = 4,
  parameter int FREEZE_CYCLES = 0,
  parameter int IDLE_CYCLES   = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_KEYS-1:0]              KEY,
  output logic                             LOCKED,
  output logic                             ERROR,
  output logic                             FROZEN,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic [6:0]                       sevenSeg
);

  localparam int DW = $clog2(NUM_KEYS);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int CW = 4;
  localparam int ZW = (FREEZE_CYCLES > 0) ? $clog2(FREEZE_CYCLES + 1) : 1;
  localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_SET, S_VERIFY, S_LOCK, S_FREEZE} state_t;
  typedef logic [CODE_LEN-1:0][DW-1:0] code_t;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] key_prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                inv_q, inv_d;
  code_t               entry_q, entry_d, cand_q, cand_d, code_q, code_d;
  logic [ZW-1:0]       frz_q, frz_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic                locked_q, locked_d, error_q, error_d, frozen_q, frozen_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [6:0]          seg_q, seg_d;

  logic [NUM_KEYS-1:0] press;
  logic                press_any, multi, expire, full_inv;
  logic [DW-1:0]       digit;
  logic [CW-1:0]       base_cnt;
  code_t               entry_full;

  function automatic logic [6:0] seg_of(input logic [CW-1:0] n);
    case (n)
      4'd0:    seg_of = 7'b0111111;
      4'd1:    seg_of = 7'b0000110;
      4'd2:    seg_of = 7'b1011011;
      4'd3:    seg_of = 7'b1001111;
      4'd4:    seg_of = 7'b1100110;
      4'd5:    seg_of = 7'b1101101;
      4'd6:    seg_of = 7'b1111101;
      4'd7:    seg_of = 7'b0000111;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  assign press     = KEY & ~key_prev_q;
  assign press_any = (|press) && (state_q != S_FREEZE);
  assign multi     = (press & (press - NUM_KEYS'(1))) != '0;
  assign expire    = (IDLE_CYCLES > 0) && (cnt_q != '0) && (idle_q == IW'(IDLE_CYCLES - 1));

  always_comb begin
    digit = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      if (press[i]) digit = DW'(i);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    entry_d  = entry_q;
    cand_d   = cand_q;
    code_d   = code_q;
    frz_d    = frz_q;
    idle_d   = '0;
    locked_d = locked_q;
    error_d  = error_q;
    frozen_d = frozen_q;
    fail_d   = fail_q;

    // An expiring timeout discards the partial entry first, so a coincident press starts afresh.
    base_cnt = expire ? '0 : cnt_q;
    full_inv = (expire ? 1'b0 : inv_q) | multi;
    if (expire) begin
      cnt_d = '0;
      inv_d = 1'b0;
    end else if ((IDLE_CYCLES > 0) && (cnt_q != '0) && !press_any) begin
      idle_d = idle_q + IW'(1);
    end

    entry_full = entry_q;
    for (int unsigned i = 0; i < CODE_LEN; i++)
      if (base_cnt == CW'(i)) entry_full[i] = digit;

    if (press_any) begin
      if (base_cnt == CW'(CODE_LEN - 1)) begin
        cnt_d = '0;
        inv_d = 1'b0;
        case (state_q)
          S_SET: begin
            if (full_inv) error_d = 1'b1;
            else begin
              cand_d  = entry_full;
              state_d = S_VERIFY;
              error_d = 1'b0;
            end
          end
          S_VERIFY: begin
            if (!full_inv && entry_full == cand_q) begin
              code_d   = entry_full;
              state_d  = S_LOCK;
              locked_d = 1'b1;
              error_d  = 1'b0;
            end else error_d = 1'b1;
          end
          S_LOCK: begin
            if (!full_inv && entry_full == code_q) begin
              state_d  = S_SET;
              locked_d = 1'b0;
              error_d  = 1'b0;
              fail_d   = '0;
            end else begin
              error_d = 1'b1;
              if (fail_q != FW'(MAX_FAILS)) fail_d = fail_q + FW'(1);
              if (fail_q == FW'(MAX_FAILS - 1)) begin
                state_d  = S_FREEZE;
                frozen_d = 1'b1;
                frz_d    = '0;
              end
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d   = base_cnt + CW'(1);
        inv_d   = full_inv;
        entry_d = entry_full;
      end
    end

    if (state_q == S_FREEZE && FREEZE_CYCLES > 0) begin
      if (frz_q == ZW'(FREEZE_CYCLES - 1)) begin
        state_d  = S_LOCK;
        frozen_d = 1'b0;
        fail_d   = '0;
        frz_d    = '0;
      end else frz_d = frz_q + ZW'(1);
    end

    seg_d = (state_d == S_FREEZE) ? 7'b1110001 : seg_of(cnt_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_SET;
      key_prev_q <= '0;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      entry_q    <= '0;
      cand_q     <= '0;
      code_q     <= '0;
      frz_q      <= '0;
      idle_q     <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      frozen_q   <= 1'b0;
      fail_q     <= '0;
      seg_q      <= 7'b0111111;
    end else begin
      state_q    <= state_d;
      key_prev_q <= KEY;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      entry_q    <= entry_d;
      cand_q     <= cand_d;
      code_q     <= code_d;
      frz_q      <= frz_d;
      idle_q     <= idle_d;
      locked_q   <= locked_d;
      error_q    <= error_d;
      frozen_q   <= frozen_d;
      fail_q     <= fail_d;
      seg_q      <= seg_d;
    end
  end

  assign LOCKED     = locked_q;
  assign ERROR      = error_q;
  assign FROZEN     = frozen_q;
  assign fail_count = fail_q;
  assign sevenSeg   = seg_q;

endmodule

// File: tb/tb_param_digital_lock.sv
// Bench for param_digital_lock: fixed vector table, directed corner sequences and
// randomized key traffic, all checked against a digit-list reference model.
module tb_param_digital_lock;
  localparam int NK = 4, CL = 4, MF = 4, FC = 64, IC = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic       LOCKED, ERROR, FROZEN;
  logic [2:0] fail_count;
  logic [6:0] sevenSeg;

  always #5 clock = ~clock;

  param_digital_lock #(
    .NUM_KEYS(NK), .CODE_LEN(CL), .MAX_FAILS(MF), .FREEZE_CYCLES(FC), .IDLE_CYCLES(IC)
  ) dut (
    .clock(clock), .reset(reset), .KEY(KEY), .LOCKED(LOCKED), .ERROR(ERROR),
    .FROZEN(FROZEN), .fail_count(fail_count), .sevenSeg(sevenSeg)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=SET 1=VERIFY 2=LOCK 3=FREEZE; entries kept as base-16 digit numbers.
  int m_mode, m_n, m_val, m_inv, m_since, m_cand, m_code, m_fails, m_frz, m_err;
  logic [3:0] m_prev;

  function automatic int seg_num(input int n);
    case (n)
      0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F; 4: return 'h66;
      5: return 'h6D; 6: return 'h7D; 7: return 'h07; 8: return 'h7F; 9: return 'h6F;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_mode = 0; m_n = 0; m_val = 0; m_inv = 0; m_since = 0;
    m_cand = 0; m_code = 0; m_fails = 0; m_frz = 0; m_err = 0; m_prev = '0;
  endtask

  task automatic m_clear_entry();
    m_n = 0; m_val = 0; m_inv = 0; m_since = 0;
  endtask

  task automatic m_step(input logic [3:0] k);
    logic [3:0] p;
    int ones, dig;
    bit expire;
    p = k & ~m_prev;
    m_prev = k;
    if (m_mode == 3) begin
      if (FC > 0) begin
        m_frz++;
        if (m_frz == FC) begin m_mode = 2; m_fails = 0; end
      end
      return;
    end
    expire = (IC > 0) && (m_n > 0) && (m_since + 1 == IC);
    if (p == 0) begin
      if (m_n > 0) begin
        m_since++;
        if (m_since == IC) m_clear_entry();
      end
      return;
    end
    if (expire) m_clear_entry();
    ones = 0; dig = 0;
    for (int i = 3; i >= 0; i--) if (p[i]) begin ones++; dig = i; end
    if (ones > 1) m_inv = 1;
    m_val = m_val * 16 + dig;
    m_n++;
    m_since = 0;
    if (m_n == CL) begin
      case (m_mode)
        0: if (m_inv != 0) m_err = 1; else begin m_cand = m_val; m_mode = 1; m_err = 0; end
        1: if (m_inv == 0 && m_val == m_cand) begin m_code = m_val; m_mode = 2; m_err = 0; end
           else m_err = 1;
        default:
          if (m_inv == 0 && m_val == m_code) begin m_mode = 0; m_err = 0; m_fails = 0; end
          else begin
            m_err = 1;
            if (m_fails < MF) m_fails++;
            if (m_fails == MF) begin m_mode = 3; m_frz = 0; end
          end
      endcase
      m_clear_entry();
    end
  endtask

  task automatic tick(input logic [3:0] k);
    KEY = k;
    @(posedge clock);
    #1;
    m_step(k);
    chk("model_seg", sevenSeg, (m_mode == 3) ? 'h71 : seg_num(m_n));
    chk("model_locked", LOCKED, (m_mode >= 2) ? 1 : 0);
    chk("model_error", ERROR, m_err);
    chk("model_frozen", FROZEN, (m_mode == 3) ? 1 : 0);
    chk("model_fail", fail_count, m_fails);
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    tick(4'b0); tick(a); tick(4'b0); tick(b); tick(4'b0); tick(c); tick(4'b0); tick(d);
  endtask

  task automatic chk_out(input string name, input int seg, input int l, input int e,
                         input int f, input int fc);
    chk({name, "_seg"}, sevenSeg, seg);
    chk({name, "_locked"}, LOCKED, l);
    chk({name, "_error"}, ERROR, e);
    chk({name, "_frozen"}, FROZEN, f);
    chk({name, "_fail"}, fail_count, fc);
  endtask

  typedef struct {
    logic [3:0] key;
    logic [6:0] seg;
    logic       locked;
    logic       error;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs = '{
      '{4'b1000, 7'h06, 0, 0}, '{4'b0100, 7'h5B, 0, 0}, '{4'b0010, 7'h4F, 0, 0},
      '{4'b0001, 7'h3F, 0, 0}, '{4'b0000, 7'h3F, 0, 0},
      '{4'b0100, 7'h06, 0, 0}, '{4'b0000, 7'h06, 0, 0}, '{4'b0100, 7'h5B, 0, 0},
      '{4'b1000, 7'h4F, 0, 0}, '{4'b0001, 7'h3F, 0, 1}, '{4'b0000, 7'h3F, 0, 1},
      '{4'b1000, 7'h06, 0, 1}, '{4'b0100, 7'h5B, 0, 1}, '{4'b0010, 7'h4F, 0, 1},
      '{4'b0001, 7'h3F, 1, 0}, '{4'b0000, 7'h3F, 1, 0}, '{4'b0000, 7'h3F, 1, 0},
      '{4'b0000, 7'h3F, 1, 0}, '{4'b0000, 7'h3F, 1, 0}
    };
    reset = 1'b0;
    KEY   = '0;
    m_reset();
    #12;
    chk_out("reset", 'h3F, 0, 0, 0, 0);
    @(posedge clock); #1 reset = 1'b1;

    // Set 3210, a wrong confirmation, then the right one.
    foreach (vecs[i]) begin
      tick(vecs[i].key);
      chk("tbl_seg", sevenSeg, vecs[i].seg);
      chk("tbl_locked", LOCKED, vecs[i].locked);
      chk("tbl_error", ERROR, vecs[i].error);
    end

    enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    chk_out("lock_wrong", 'h3F, 1, 1, 0, 1);
    enter(4'b1000, 4'b0100, 4'b0010, 4'b0001);
    chk_out("lock_open", 'h3F, 0, 0, 0, 0);

    enter(4'b1000, 4'b0100, 4'b0010, 4'b0001);
    enter(4'b1000, 4'b0100, 4'b0010, 4'b0001);
    chk_out("relock", 'h3F, 1, 0, 0, 0);
    for (int n = 0; n < 4; n++) enter(4'b0001, 4'b0001, 4'b0001, 4'b0001);
    chk_out("freeze_enter", 'h71, 1, 1, 1, 4);
    for (int n = 0; n < 63; n++) tick(4'($urandom_range(0, 15)));
    chk_out("freeze_hold", 'h71, 1, 1, 1, 4);
    tick(4'b0);
    chk_out("freeze_exit", 'h3F, 1, 1, 0, 0);

    tick(4'b1000);
    for (int n = 0; n < 31; n++) tick(4'b0);
    chk("idle_before", sevenSeg, 'h06);
    tick(4'b0);
    chk_out("idle_expire", 'h3F, 1, 1, 0, 0);
    tick(4'b1000);
    for (int n = 0; n < 31; n++) tick(4'b0);
    tick(4'b0100);
    chk("idle_press_wins", sevenSeg, 'h06);
    for (int n = 0; n < 32; n++) tick(4'b0);
    chk("idle_second", sevenSeg, 'h3F);

    enter(4'b1000, 4'b0100, 4'b0010, 4'b0001);
    chk_out("open2", 'h3F, 0, 0, 0, 0);
    enter(4'b0001, 4'b0010, 4'b0100, 4'b1100);
    chk_out("set_invalid", 'h3F, 0, 1, 0, 0);
    enter(4'b0001, 4'b0010, 4'b0001, 4'b0010);
    chk_out("set_after_invalid", 'h3F, 0, 0, 0, 0);
    enter(4'b0001, 4'b0010, 4'b0001, 4'b0010);
    chk_out("verify_new", 'h3F, 1, 0, 0, 0);

    for (int n = 0; n < 4; n++) enter(4'b0001, 4'b0001, 4'b0001, 4'b0001);
    chk_out("freeze2", 'h71, 1, 1, 1, 4);
    #3 reset = 1'b0;
    #1;
    chk_out("async_reset", 'h3F, 0, 0, 0, 0);
    m_reset();
    KEY = 4'b1000;
    @(posedge clock); #1 reset = 1'b1;
    tick(4'b1000);
    chk("held_at_release", sevenSeg, 'h06);

    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        int gap;
        gap = $urandom_range(25, 40);
        for (int g = 0; g < gap; g++) tick(4'b0);
      end else if (r < 50) tick(4'b0);
      else if (r < 92) tick(4'(1 << $urandom_range(0, 1)));
      else if (r < 96) tick(4'(1 << $urandom_range(2, 3)));
      else tick(4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_digital_lock.md
PARAM_DIGITAL_LOCK -- requirements
Module: param_digital_lock

Interface
REQ-001 The block SHALL have the following parameters:
  - NUM_KEYS, default 4: number of keypad keys; must be 2..16.
  - CODE_LEN, default 4: digits per combination; must be 1..9.
  - MAX_FAILS, default 4: consecutive failed unlock attempts before freeze; must be >= 1.
  - FREEZE_CYCLES, default 0: freeze duration in clocks; 0 means frozen until reset.
  - IDLE_CYCLES, default 0: inactivity timeout that discards a partial entry; 0 disables it.
REQ-002 The block SHALL have the following ports (clock and reset first):
  - clock, input, 1: the single clock; all state changes on its rising edge.
  - reset, input, 1: asynchronous, active-low reset.
  - KEY, input, NUM_KEYS: raw key levels, active-high.
  - LOCKED, output, 1: lock engaged.
  - ERROR, output, 1: last completed entry was rejected.
  - FROZEN, output, 1: block is in the FREEZE state.
  - fail_count, output, clog2(MAX_FAILS+1): consecutive failed unlock attempts.
  - sevenSeg, output, 7: active-high segments, gfedcba order, bit0 = a.
REQ-003 The block SHALL register every output; there SHALL be no combinational path from KEY to any output.

Function
REQ-004 A press SHALL be a rising edge on any KEY bit (KEY & ~KEY_prev), evaluated every clock; a held key SHALL count once.
REQ-005 A press with exactly one bit set SHALL yield digit = index of that bit; a press with more than one bit set SHALL count as a digit and SHALL mark the current entry invalid.
REQ-006 Each press outside FREEZE SHALL increment the digit counter and store the digit, with the result visible after the sampling edge (1-cycle latency from KEY rising).
REQ-007 sevenSeg SHALL show the digit counter as decimal 0..9 ("0"=0111111, "1"=0000110, "2"=1011011, "3"=1001111, "4"=1100110). In FREEZE it SHALL show "F"=1110001.
REQ-008 The state machine SHALL have states SET, VERIFY, LOCK and FREEZE.
REQ-009 On the press that completes CODE_LEN digits, the entry SHALL be evaluated on that same edge, and the digit counter SHALL return to 0.
REQ-010 SET: the completed entry SHALL be stored as the candidate code, then go to VERIFY, with ERROR=0.
  - An invalid entry SHALL instead set ERROR=1 and stay in SET.
REQ-011 VERIFY: a valid entry equal to the candidate SHALL commit the code, go to LOCK with LOCKED=1 and ERROR=0.
  - A mismatch SHALL set ERROR=1 and stay in VERIFY.
REQ-012 LOCK: a valid entry equal to the committed code SHALL clear LOCKED, ERROR and fail_count, then go to SET.
  - A mismatch SHALL set ERROR=1 and increment fail_count.
REQ-013 When fail_count reaches MAX_FAILS, the block SHALL enter FREEZE on that edge with LOCKED=1, ERROR=1, FROZEN=1.
REQ-014 FREEZE: all presses SHALL be ignored.
  - With FREEZE_CYCLES>0, after exactly FREEZE_CYCLES clocks the block SHALL return to LOCK with fail_count=0, FROZEN=0, ERROR=1 retained.
  - With FREEZE_CYCLES=0 it SHALL remain frozen until reset.
REQ-015 Inactivity timeout: if IDLE_CYCLES>0 and the digit counter is nonzero with no press for IDLE_CYCLES clocks, the partial entry SHALL be discarded and the counter cleared.
  - The timeout SHALL NOT count a failure, change ERROR or change state.
REQ-016 A press on the same edge that the idle timeout expires SHALL win; it SHALL count as digit 1 of a new entry.
REQ-017 The digit count SHALL never exceed CODE_LEN.
REQ-018 The freeze counter SHALL saturate and SHALL NOT wrap.
REQ-019 fail_count SHALL saturate at MAX_FAILS.

Reset
REQ-020 Asserting reset (low) SHALL immediately, independent of clock, force:
  - state=SET, LOCKED=0, ERROR=0, FROZEN=0, fail_count=0;
  - digit counter=0, sevenSeg=0111111;
  - KEY_prev=0; candidate and committed codes=0; freeze and idle counters=0.
REQ-021 Reset mid-entry or mid-freeze SHALL abandon all progress.
REQ-022 A KEY bit already high when reset releases SHALL register as a press on the first clock.

Verification (defaults, except FREEZE_CYCLES=64 and IDLE_CYCLES=32)
REQ-023 Reset, press 1000 -> sevenSeg=0000110 one clock later; then 0100, 0010, 0001 -> VERIFY, LOCKED=0.
REQ-024 In VERIFY enter 0100,0100,1000,0001 -> ERROR=1, still VERIFY; then 1000,0100,0010,0001 -> LOCKED=1, ERROR=0.
REQ-025 In LOCK enter one wrong code -> LOCKED=1, ERROR=1, fail_count=1; then the correct code -> LOCKED=0, fail_count=0, state SET.
REQ-026 In LOCK enter 4 wrong codes -> FROZEN=1, LOCKED=1, ERROR=1, sevenSeg=1110001; presses are ignored; after 64 clocks FROZEN=0, fail_count=0.
REQ-027 Press 1000 then idle 32 clocks -> sevenSeg=0111111, state unchanged; press 1100 in the last digit of an entry in SET -> ERROR=1, stays SET.
REQ-028 Assert reset while FROZEN -> all outputs at reset values before the next clock edge.
